// File: rtl/axis_pkg.sv
// rtl/axis_pkg.sv - shared widths, write-side state enum and byte-count helper
package axis_pkg;

    localparam int AXIS_DATA_W = 64;
    localparam int AXIS_KEEP_W = 8;
    localparam int LEN_W       = 16;
    localparam int BEAT_W      = 1 + AXIS_KEEP_W + AXIS_DATA_W;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_FILL = 2'd1,
        WR_DROP = 2'd2
    } wr_state_t;

    function automatic logic [LEN_W-1:0] keep_bytes(input logic [AXIS_KEEP_W-1:0] keep);
        logic [LEN_W-1:0] n;
        n = '0;
        for (int i = 0; i < AXIS_KEEP_W; i++) begin
            n = n + LEN_W'(keep[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/axis_pkt_store_if.sv
// rtl/axis_pkt_store_if.sv - one stream channel with tdata/tkeep/tlast/tvalid/tready
interface axis_pkt_store_if
    import axis_pkg::*;
#(
    parameter int DATA_W = AXIS_DATA_W,
    parameter int KEEP_W = AXIS_KEEP_W
);
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tlast;

    modport master (
        output tvalid,
        output tdata,
        output tkeep,
        output tlast,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tkeep,
        input  tlast,
        output tready
    );

endinterface

// File: rtl/sdp_ram.sv
// rtl/sdp_ram.sv - simple dual-port RAM, one write port, registered read port with hold
module sdp_ram
    import axis_pkg::*;
#(
    parameter int WIDTH = BEAT_W,
    parameter int DEPTH = 512,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // The read register doubles as the egress output register, so it holds when rd_en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/axis_pkt_store.sv
// rtl/axis_pkt_store.sv - store-and-forward packet buffer with byte-length queue and drop on overflow
module axis_pkt_store
    import axis_pkg::*;
#(
    parameter int DATA_DEPTH = 512,
    parameter int LEN_DEPTH  = 16
) (
    input  logic             axis_aclk,
    input  logic             axis_aresetn,
    axis_pkt_store_if.slave  s_axis,
    axis_pkt_store_if.master m_axis,
    axis_pkt_store_if.master m_len,
    output logic [LEN_W-1:0] drop_cnt
);

    localparam int AW = $clog2(DATA_DEPTH);
    localparam int LW = $clog2(LEN_DEPTH);

    wr_state_t        state;
    wr_state_t        state_nx;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    wr_ptr_nx;
    logic [AW-1:0]    commit_ptr;
    logic [AW-1:0]    commit_ptr_nx;
    logic [AW-1:0]    rd_ptr;
    logic [LEN_W-1:0] acc;
    logic [LEN_W-1:0] acc_nx;
    logic [LEN_W-1:0] beat_bytes;
    logic [LEN_W-1:0] pkt_len;
    logic             ready_en;
    logic             accept;
    logic             buf_full;
    logic             ram_we;
    logic             len_push;
    logic             drop_hit;

    logic [LW:0]      len_wr_ptr;
    logic [LW:0]      len_rd_ptr;
    logic [LEN_W-1:0] len_mem [LEN_DEPTH];
    logic             len_full;
    logic             len_pop;

    logic             m_valid;
    logic             rd_issue;
    logic [BEAT_W-1:0] ram_rd_data;

    // ------------------------------------------------------------------ write side
    assign beat_bytes = keep_bytes(s_axis.tkeep);
    assign pkt_len    = acc + beat_bytes;
    // One slot stays empty so a full buffer is distinguishable from an empty one.
    assign buf_full   = (wr_ptr + AW'(1)) == rd_ptr;
    assign len_full   = (len_wr_ptr[LW] != len_rd_ptr[LW]) &&
                        (len_wr_ptr[LW-1:0] == len_rd_ptr[LW-1:0]);

    assign s_axis.tready = ready_en && (!len_full || state == WR_DROP);
    assign accept        = s_axis.tvalid && s_axis.tready;

    always_comb begin
        state_nx      = state;
        wr_ptr_nx     = wr_ptr;
        commit_ptr_nx = commit_ptr;
        acc_nx        = acc;
        ram_we        = 1'b0;
        len_push      = 1'b0;
        drop_hit      = 1'b0;
        if (accept) begin
            case (state)
                WR_IDLE, WR_FILL: begin
                    if (buf_full) begin
                        wr_ptr_nx = commit_ptr;
                        acc_nx    = '0;
                        drop_hit  = 1'b1;
                        state_nx  = s_axis.tlast ? WR_IDLE : WR_DROP;
                    end else begin
                        ram_we    = 1'b1;
                        wr_ptr_nx = wr_ptr + AW'(1);
                        if (s_axis.tlast) begin
                            len_push      = 1'b1;
                            commit_ptr_nx = wr_ptr + AW'(1);
                            acc_nx        = '0;
                            state_nx      = WR_IDLE;
                        end else begin
                            acc_nx   = pkt_len;
                            state_nx = WR_FILL;
                        end
                    end
                end
                WR_DROP: begin
                    if (s_axis.tlast) begin
                        state_nx = WR_IDLE;
                    end
                end
                default: state_nx = WR_IDLE;
            endcase
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state      <= WR_IDLE;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            acc        <= '0;
            drop_cnt   <= '0;
            ready_en   <= 1'b0;
        end else begin
            state      <= state_nx;
            wr_ptr     <= wr_ptr_nx;
            commit_ptr <= commit_ptr_nx;
            acc        <= acc_nx;
            ready_en   <= 1'b1;
            if (drop_hit && drop_cnt != '1) begin
                drop_cnt <= drop_cnt + LEN_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------ length queue
    assign len_pop      = m_len.tvalid && m_len.tready;
    assign m_len.tvalid = len_wr_ptr != len_rd_ptr;
    assign m_len.tdata  = len_mem[len_rd_ptr[LW-1:0]];
    assign m_len.tkeep  = '1;
    assign m_len.tlast  = 1'b1;

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            len_wr_ptr <= '0;
            len_rd_ptr <= '0;
            for (int i = 0; i < LEN_DEPTH; i++) begin
                len_mem[i] <= '0;
            end
        end else begin
            if (len_push) begin
                len_mem[len_wr_ptr[LW-1:0]] <= pkt_len;
                len_wr_ptr                  <= len_wr_ptr + (LW+1)'(1);
            end
            if (len_pop) begin
                len_rd_ptr <= len_rd_ptr + (LW+1)'(1);
            end
        end
    end

    // ------------------------------------------------------------------ egress
    // Reads stop at commit_ptr, so an open or rewinding packet is never visible here.
    assign rd_issue = (!m_valid || m_axis.tready) && (rd_ptr != commit_ptr);

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            rd_ptr  <= '0;
            m_valid <= 1'b0;
        end else if (rd_issue) begin
            rd_ptr  <= rd_ptr + AW'(1);
            m_valid <= 1'b1;
        end else if (m_axis.tready) begin
            m_valid <= 1'b0;
        end
    end

    sdp_ram #(
        .WIDTH (BEAT_W),
        .DEPTH (DATA_DEPTH)
    ) u_ram (
        .clk     (axis_aclk),
        .rst_n   (axis_aresetn),
        .wr_en   (ram_we),
        .wr_addr (wr_ptr),
        .wr_data ({s_axis.tlast, s_axis.tkeep, s_axis.tdata}),
        .rd_en   (rd_issue),
        .rd_addr (rd_ptr),
        .rd_data (ram_rd_data)
    );

    assign m_axis.tvalid = m_valid;
    assign m_axis.tlast  = ram_rd_data[BEAT_W-1];
    assign m_axis.tkeep  = ram_rd_data[AXIS_DATA_W +: AXIS_KEEP_W];
    assign m_axis.tdata  = ram_rd_data[AXIS_DATA_W-1:0];

endmodule

// File: doc/axis_pkt_store.md
AXIS_PKT_STORE -- requirements
Module: axis_pkt_store

Interface
REQ-001 Parameter DATA_DEPTH, default 512, payload buffer depth in 64-bit beats; SHALL be a power of two.
REQ-002 Parameter LEN_DEPTH, default 16, length-queue depth in packets; SHALL be a power of two.
REQ-003 Clocking and reset SHALL be one clock and an asynchronous active-low reset: axis_aclk  in  1  sole clock, all logic rising-edge.
REQ-004 axis_aresetn  in  1  asynchronous active-low reset.
REQ-005 s_axis_tvalid / s_axis_tready  in / out  1 / 1  ingress handshake.
REQ-006 s_axis_tdata  in  64  ingress payload, byte 0 at bits [7:0].
REQ-007 s_axis_tkeep  in  8  ingress byte enables; s_axis_tlast  in  1  end of packet.
REQ-008 m_axis_tvalid / m_axis_tready  out / in  1 / 1  egress handshake.
REQ-009 m_axis_tdata  out  64,  m_axis_tkeep  out  8,  m_axis_tlast  out  1: egress beat, bit-identical to ingress.
REQ-010 m_len_tvalid / m_len_tready  out / in  1 / 1  packet-length handshake.
REQ-011 m_len_tdata  out  16  byte length of the oldest committed packet not yet popped.
REQ-012 drop_cnt  out  16  count of dropped packets, saturating at 16'hFFFF.

Function
REQ-013 Block SHALL be store-and-forward: no beat of a packet appears on m_axis before that packet's tlast beat is accepted and committed.
REQ-014 Byte length SHALL be the sum of popcount(s_axis_tkeep) over all accepted beats of the packet; tkeep=0 beat adds 0 bytes.
REQ-015 s_axis_tready SHALL be 1 when length queue not full, or when in DROP state; otherwise 0.
REQ-016 Write side states: IDLE (no open packet), FILL (packet open), DROP (discarding remainder).
REQ-017 IDLE/FILL, accepted beat, buffer not full: write {tlast,tkeep,tdata} at wr_ptr, wr_ptr+1, accumulate length.
REQ-018 Accepted tlast beat written: push length to queue, commit_ptr <= new wr_ptr, clear accumulator, go IDLE.
REQ-019 Accepted beat when buffer full (wr_ptr+1 == rd_ptr mod DATA_DEPTH, one slot reserved): discard beat, wr_ptr <= commit_ptr, clear accumulator, drop_cnt+1 (saturating), go DROP; if that beat has tlast, go IDLE instead.
REQ-020 DROP: accepted beats discarded; accepted tlast beat -> IDLE; no length pushed.
REQ-021 Egress SHALL present data only when rd_ptr != commit_ptr; m_axis outputs registered, RAM read latency 1, full throughput (1 beat/cycle under continuous m_axis_tready).
REQ-022 m_axis outputs SHALL hold stable while tvalid=1 and tready=0.
REQ-023 Length queue and egress data SHALL be independently handshaked; m_len_tvalid rises no earlier than cycle after commit; first data beat of a packet valid no earlier than 2 cycles after its tlast beat accepted.
REQ-024 Simultaneous length push and pop SHALL both succeed; queue occupancy unchanged.
REQ-025 Simultaneous ingress write, drop rewind and egress read SHALL be consistent: egress never reads beyond commit_ptr.
REQ-026 Pointers SHALL wrap modulo DATA_DEPTH / LEN_DEPTH with no lost or duplicated entries.

Reset
REQ-027 On axis_aresetn=0 asynchronously: all pointers 0, state IDLE, accumulator 0, drop_cnt 0, s_axis_tready 0, m_axis_tvalid 0, m_axis_tdata/tkeep/tlast 0, m_len_tvalid 0, m_len_tdata 0.
REQ-028 Reset mid-packet SHALL discard all stored and in-flight packets; RAM contents need not be cleared.
REQ-029 s_axis_tready SHALL rise no earlier than the first clock edge after reset deassertion.

Structure
REQ-030 Shared package axis_pkg SHALL hold AXIS_DATA_W=64, AXIS_KEEP_W=8, LEN_W=16 and the write-state enum.
REQ-031 Payload storage SHALL be one sub-module sdp_ram (simple dual-port, registered read, width 73, depth DATA_DEPTH); length queue inline.

Verification
REQ-032 One packet, 20 beats tkeep=FF + last beat tkeep=0F -> m_len_tdata=164, 21 egress beats identical, last tlast=1 tkeep=0F.
REQ-033 Back-to-back 21-beat and 41-beat packets (last tkeep=0F), tready=1 -> lengths 164 then 324 in order, data order preserved, drop_cnt=0.
REQ-034 DATA_DEPTH=16, 20-beat packet with m_axis_tready=0 -> packet dropped, drop_cnt=1, no length pushed; next 4-beat packet delivered, length 32.
REQ-035 LEN_DEPTH=4, m_len_tready=0, 5 one-beat packets -> s_axis_tready=0 after 4th; raising m_len_tready resumes, 5 lengths popped in order.
REQ-036 Reset asserted mid-packet then released -> all outputs at reset values, no stale beat or length emitted; next packet correct.
REQ-037 Random tvalid/tready/m_len_tready throttling, 1000 packets, lengths 1..512 bytes -> egress data and lengths match scoreboard, pointers wrap cleanly.
